// File: rtl/tz_secure_mailbox.sv
// TrustZone mailbox: per-channel security-tagged FIFOs with attribute checks on
// write/read/config, a saturating violation counter and non-secure lockdown.

module tz_mb_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         scrub,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // push targets a free slot and scrub a live one, so the addresses never collide
  always_ff @(posedge clk) begin
    if (push)  mem[wp[AW-1:0]] <= din;
    if (scrub) mem[rp[AW-1:0]] <= '0;
  end

  assign head  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module tz_secure_mailbox #(
  parameter  int DATA_W     = 32,
  parameter  int NCH        = 4,
  parameter  int DEPTH      = 4,
  parameter  int CNT_W      = 4,
  parameter  int VIOL_LIMIT = 3,
  localparam int CH_W       = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sec,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic              rd_sec,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_secure_only,
  input  logic              cfg_sec,
  input  logic              lock_clr,
  output logic [NCH-1:0]    secure_only,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    full,
  output logic [CNT_W-1:0]  viol_count,
  output logic              locked,
  output logic              irq_viol
);
  typedef enum logic [1:0] {S_OPEN, S_ALERT, S_LOCKED} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                     state;
  logic [NCH-1:0][DATA_W:0]   head;
  logic [NCH-1:0]             push, pop, scrub;
  logic                       wv, cv, rv, rd_lock, rd_mt, pop_ok, push_ok;
  logic [1:0]                 inc;
  logic [CNT_W:0]             cnt_sum;

  assign locked   = (state == S_LOCKED);
  assign wv       = wr_valid & wr_sec & (secure_only[wr_ch] | locked);
  assign cv       = cfg_we & cfg_sec;
  assign wr_ready = wv | ~full[wr_ch];
  assign push_ok  = wr_valid & ~wv & ~full[wr_ch];

  assign rd_lock  = rd_req & rd_sec & locked;
  assign rd_mt    = rd_req & ~rd_lock & empty[rd_ch];
  assign pop_ok   = rd_req & ~rd_lock & ~empty[rd_ch];
  // non-secure reader hitting a secure-tagged head burns the entry
  assign rv       = pop_ok & rd_sec & ~head[rd_ch][DATA_W];

  assign inc      = 2'(wv) + 2'(rd_lock | rv) + 2'(cv);
  assign cnt_sum  = {1'b0, viol_count} + (CNT_W+1)'(inc);

  always_comb begin
    push  = '0;
    pop   = '0;
    scrub = '0;
    if (push_ok) push[wr_ch]  = 1'b1;
    if (pop_ok)  pop[rd_ch]   = 1'b1;
    if (rv)      scrub[rd_ch] = 1'b1;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tz_mb_fifo #(.W(DATA_W+1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .scrub (scrub[c]),
      .din   ({wr_sec, wr_data}),
      .head  (head[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_lock | rd_mt | rv;
      rd_data  <= (pop_ok & ~rv) ? head[rd_ch][DATA_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) secure_only <= '1;
    else if (cfg_we && !cfg_sec) secure_only[cfg_ch] <= cfg_secure_only;
  end

  // state follows last cycle's count, so lock lags the count by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OPEN;
      viol_count <= '0;
      irq_viol   <= 1'b0;
    end else begin
      irq_viol <= |inc;
      if (lock_clr)          viol_count <= '0;
      else if (cnt_sum[CNT_W]) viol_count <= CNT_MAX;
      else                   viol_count <= cnt_sum[CNT_W-1:0];
      if (lock_clr)                              state <= S_OPEN;
      else if (viol_count >= CNT_W'(VIOL_LIMIT)) state <= S_LOCKED;
      else if (viol_count != '0)                 state <= S_ALERT;
      else                                       state <= S_OPEN;
    end
  end
endmodule

// File: tb/tb_tz_secure_mailbox.sv
// Directed bench for tz_secure_mailbox: queue-based reference model checked every
// cycle, plus literal expectations along the directed sequence.

module tb_tz_secure_mailbox;
  localparam int DATA_W = 32, NCH = 4, DEPTH = 4, CNT_W = 4, VIOL_LIMIT = 3;
  localparam int CH_W = 2, CMAX = 15;

  logic clk, rst_n;
  logic wr_valid, wr_ready, wr_sec;
  logic [CH_W-1:0] wr_ch, rd_ch, cfg_ch;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic rd_req, rd_sec, rd_valid, rd_err;
  logic cfg_we, cfg_secure_only, cfg_sec, lock_clr;
  logic [NCH-1:0] secure_only, empty, full;
  logic [CNT_W-1:0] viol_count;
  logic locked, irq_viol;

  tz_secure_mailbox #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W),
                      .VIOL_LIMIT(VIOL_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_data(wr_data), .wr_sec(wr_sec), .rd_req(rd_req), .rd_ch(rd_ch), .rd_sec(rd_sec),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_secure_only(cfg_secure_only), .cfg_sec(cfg_sec),
    .lock_clr(lock_clr), .secure_only(secure_only), .empty(empty), .full(full),
    .viol_count(viol_count), .locked(locked), .irq_viol(irq_viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: one queue of {tag,data} per channel
  logic [DATA_W:0] q [NCH][$];
  logic [NCH-1:0] m_so;
  int m_cnt;
  logic m_lock, m_irq, m_rv, m_rerr;
  logic [DATA_W-1:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    int v;
    bit wv, fullp;
    logic [DATA_W:0] h;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) q[c].delete();
      m_so <= '1; m_cnt <= 0; m_lock <= 0; m_irq <= 0;
      m_rv <= 0; m_rerr <= 0; m_rdata <= '0;
    end else begin
      v = 0;
      fullp = (q[wr_ch].size() == DEPTH);
      wv = wr_valid && wr_sec && (m_so[wr_ch] || m_lock);
      if (wv) v++;
      if (cfg_we && cfg_sec) v++;
      m_rv <= rd_req; m_rerr <= 0; m_rdata <= '0;
      if (rd_req) begin
        if (rd_sec && m_lock) begin m_rerr <= 1; v++; end
        else if (q[rd_ch].size() == 0) m_rerr <= 1;
        else begin
          h = q[rd_ch].pop_front();
          if (!h[DATA_W] && rd_sec) begin m_rerr <= 1; v++; end
          else m_rdata <= h[DATA_W-1:0];
        end
      end
      if (wr_valid && !wv && !fullp) q[wr_ch].push_back({wr_sec, wr_data});
      if (cfg_we && !cfg_sec) m_so[cfg_ch] <= cfg_secure_only;
      m_irq  <= (v > 0);
      m_lock <= lock_clr ? 1'b0 : (m_cnt >= VIOL_LIMIT);
      m_cnt  <= lock_clr ? 0 : ((m_cnt + v > CMAX) ? CMAX : m_cnt + v);
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] e_mt, e_fu;
    bit e_rdy;
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        e_mt[c] = (q[c].size() == 0);
        e_fu[c] = (q[c].size() == DEPTH);
      end
      e_rdy = (wr_valid && wr_sec && (m_so[wr_ch] || m_lock)) || !e_fu[wr_ch];
      chk("m_empty", 32'(empty), 32'(e_mt));
      chk("m_full", 32'(full), 32'(e_fu));
      chk("m_secure_only", 32'(secure_only), 32'(m_so));
      chk("m_viol_count", 32'(viol_count), 32'(m_cnt));
      chk("m_locked", 32'(locked), 32'(m_lock));
      chk("m_irq_viol", 32'(irq_viol), 32'(m_irq));
      chk("m_wr_ready", 32'(wr_ready), 32'(e_rdy));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_rv));
      if (m_rv) begin
        chk("m_rd_err", 32'(rd_err), 32'(m_rerr));
        chk("m_rd_data", rd_data, m_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_valid = 0; wr_ch = '0; wr_data = '0; wr_sec = 0;
    rd_req = 0; rd_ch = '0; rd_sec = 0;
    cfg_we = 0; cfg_ch = '0; cfg_secure_only = 0; cfg_sec = 0; lock_clr = 0;
  endtask

  task automatic wr(input int ch, input logic [31:0] d, input logic s, input logic rdy);
    wr_valid = 1; wr_ch = CH_W'(ch); wr_data = d; wr_sec = s;
    #1 chk("wr_ready", 32'(wr_ready), 32'(rdy));
    tick();
    wr_valid = 0;
  endtask

  task automatic rd(input int ch, input logic s, input logic [31:0] d, input logic err);
    rd_req = 1; rd_ch = CH_W'(ch); rd_sec = s;
    tick();
    rd_req = 0;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_err", 32'(rd_err), 32'(err));
    chk("rd_data", rd_data, d);
  endtask

  task automatic cfg(input int ch, input logic val, input logic s);
    cfg_we = 1; cfg_ch = CH_W'(ch); cfg_secure_only = val; cfg_sec = s;
    tick();
    cfg_we = 0;
  endtask

  task automatic clr();
    lock_clr = 1; tick(); lock_clr = 0;
  endtask

  initial begin
    logic [31:0] d;
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_secure_only", 32'(secure_only), 32'hF);
    chk("rst_count", 32'(viol_count), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    tick();

    // non-secure write to secure channel: consumed, dropped, counted
    wr(0, 32'hDEADBEEF, 1, 1);
    chk("wv_empty0", 32'(empty[0]), 32'd1);
    chk("wv_count", 32'(viol_count), 32'd1);
    chk("wv_irq", 32'(irq_viol), 32'd1);
    tick();
    chk("wv_irq_off", 32'(irq_viol), 32'd0);

    cfg(1, 0, 0);
    chk("cfg_so1", 32'(secure_only), 32'hD);
    wr(1, 32'h11, 1, 1); wr(1, 32'h22, 1, 1); wr(1, 32'h33, 1, 1); wr(1, 32'h44, 1, 1);
    chk("full1", 32'(full[1]), 32'd1);
    wr(1, 32'h55, 1, 0);
    rd(1, 1, 32'h11, 0); rd(1, 1, 32'h22, 0); rd(1, 1, 32'h33, 0); rd(1, 1, 32'h44, 0);
    chk("empty1", 32'(empty[1]), 32'd1);

    wr(0, 32'hCAFE0001, 0, 1);
    rd(0, 1, 32'h0, 1);
    chk("rv_empty0", 32'(empty[0]), 32'd1);
    chk("rv_count", 32'(viol_count), 32'd2);
    rd(0, 0, 32'h0, 1);
    chk("mt_count", 32'(viol_count), 32'd2);

    // three violations in one cycle
    clr();
    wr(0, 32'h55, 0, 1);
    wr_valid = 1; wr_ch = 0; wr_data = 32'h99; wr_sec = 1;
    cfg_we = 1; cfg_ch = 0; cfg_secure_only = 0; cfg_sec = 1;
    rd_req = 1; rd_ch = 0; rd_sec = 1;
    tick();
    idle();
    chk("tri_count", 32'(viol_count), 32'd3);
    chk("tri_locked_pre", 32'(locked), 32'd0);
    chk("tri_rd_err", 32'(rd_err), 32'd1);
    chk("tri_rd_data", rd_data, 32'h0);
    tick();
    chk("tri_locked", 32'(locked), 32'd1);
    wr(2, 32'h77, 0, 1);
    rd(2, 0, 32'h77, 0);
    rd(1, 1, 32'h0, 1);
    chk("lock_rd_count", 32'(viol_count), 32'd4);

    lock_clr = 1; cfg_we = 1; cfg_sec = 1;
    tick();
    idle();
    chk("clr_count", 32'(viol_count), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    repeat (17) cfg(0, 0, 1);
    chk("sat_count", 32'(viol_count), 32'd15);
    clr();
    tick();
    chk("sat_clr", 32'(locked), 32'd0);

    // ten fill/drain rounds on ch3
    cfg(3, 0, 0);
    d = 1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) wr(3, d + 32'(i), 1, 1);
      chk("fd_full", 32'(full[3]), 32'd1);
      for (int i = 0; i < 4; i++) rd(3, 1, d + 32'(i), 0);
      chk("fd_empty", 32'(empty[3]), 32'd1);
      d += 4;
    end

    // same-cycle write+read, full then empty
    for (int i = 0; i < 4; i++) wr(3, 32'hA1 + 32'(i), 1, 1);
    rd_req = 1; rd_ch = 3; rd_sec = 1;
    wr(3, 32'hBB, 1, 0);
    idle();
    chk("wrrd_full_data", rd_data, 32'hA1);
    rd(3, 1, 32'hA2, 0); rd(3, 1, 32'hA3, 0); rd(3, 1, 32'hA4, 0);
    rd_req = 1; rd_ch = 3; rd_sec = 1;
    wr(3, 32'hCC, 1, 1);
    idle();
    chk("wrrd_empty_err", 32'(rd_err), 32'd1);
    chk("wrrd_empty_push", 32'(empty[3]), 32'd0);
    rd(3, 1, 32'hCC, 0);

    // reset mid-operation
    wr(3, 32'h1, 1, 1);
    rd_req = 1; rd_ch = 3; rd_sec = 1;
    rst_n = 0;
    #1;
    chk("mid_rst_empty", 32'(empty), 32'hF);
    chk("mid_rst_so", 32'(secure_only), 32'hF);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    idle();
    #1 rst_n = 1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
